// File: rtl/mlp_frame_sequencer_if.sv
// mlp_frame_sequencer_if: feature stream, core bus and result
// port of the MLP frame sequencer, bundled for one connection.
interface mlp_frame_sequencer_if #(
  parameter int NUM_A    = 21,
  parameter int WIDTH_A  = 4,
  parameter int OUTWIDTH = 2,
  parameter int CNT_W    = 16
);
  logic                     s_valid;
  logic                     s_ready;
  logic [WIDTH_A-1:0]       s_data;
  logic                     s_last;
  logic [NUM_A*WIDTH_A-1:0] inp;
  logic [OUTWIDTH-1:0]      mlp_out;
  logic                     m_valid;
  logic                     m_ready;
  logic [OUTWIDTH-1:0]      m_class;
  logic                     frame_err;
  logic [CNT_W-1:0]         frames_done;

  modport master (
    output s_valid, s_data, s_last,
    output mlp_out, m_ready,
    input  s_ready, inp, m_valid,
    input  m_class, frame_err, frames_done
  );

  modport slave (
    input  s_valid, s_data, s_last,
    input  mlp_out, m_ready,
    output s_ready, inp, m_valid,
    output m_class, frame_err, frames_done
  );
endinterface

// File: rtl/mlp_frame_sequencer.sv
// mlp_frame_sequencer: assembles serial features into the MLP
// input bus, waits a settle window, then returns the class.
module mlp_frame_sequencer #(
  parameter int NUM_A         = 21,
  parameter int WIDTH_A       = 4,
  parameter int OUTWIDTH      = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mlp_frame_sequencer_if.slave   bus
);
  localparam int IW = (NUM_A > 1) ? $clog2(NUM_A) : 1;
  localparam int SW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [IW-1:0] IDX_END  = IW'(NUM_A - 1);
  localparam logic [SW-1:0] CNT_INIT = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD,
    SETTLE,
    OUT
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [IW-1:0]            r_idx;
  logic [SW-1:0]            r_cnt;
  logic [NUM_A*WIDTH_A-1:0] r_inp;
  logic                     r_mvalid;
  logic [OUTWIDTH-1:0]      r_mclass;
  logic                     r_err;
  logic [CNT_W-1:0]         r_done;

  logic w_acc;
  logic w_end;
  logic w_fire;
  logic w_out_hs;

  assign w_acc    = (r_state == LOAD) && bus.s_valid;
  assign w_end    = (r_idx == IDX_END);
  assign w_fire   = (r_state == SETTLE) && (r_cnt == '0);
  assign w_out_hs = (r_state == OUT) && bus.m_ready;

  assign bus.s_ready     = (r_state == LOAD);
  assign bus.inp         = r_inp;
  assign bus.m_valid     = r_mvalid;
  assign bus.m_class     = r_mclass;
  assign bus.frame_err   = r_err;
  assign bus.frames_done = r_done;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= LOAD;
    else        r_state <= w_next;
  end

  // Next-state decode: load, settle countdown, result handshake.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      LOAD:    if (w_acc && w_end) w_next = SETTLE;
      SETTLE:  if (r_cnt == '0)    w_next = OUT;
      OUT:     if (bus.m_ready)    w_next = LOAD;
      default: w_next = LOAD;
    endcase
  end

  // Feature slot index; a short frame or a full frame restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (w_acc) begin
      if (w_end || bus.s_last) r_idx <= '0;
      else                     r_idx <= r_idx + 1'b1;
    end
  end

  // Slot k only changes on the edge that accepts beat k.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inp <= '0;
    end else begin
      for (int k = 0; k < NUM_A; k++) begin
        if (w_acc && (r_idx == IW'(k)))
          r_inp[k*WIDTH_A +: WIDTH_A] <= bus.s_data;
      end
    end
  end

  // Settle countdown, armed by the final beat of a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_acc && w_end) begin
      r_cnt <= CNT_INIT;
    end else if ((r_state == SETTLE) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Framing error: s_last disagrees with the slot position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= w_acc && (w_end != bus.s_last);
  end

  // Result capture in the last settle cycle, held until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mvalid <= 1'b0;
      r_mclass <= '0;
    end else if (w_fire) begin
      r_mvalid <= 1'b1;
      r_mclass <= bus.mlp_out;
    end else if (w_out_hs) begin
      r_mvalid <= 1'b0;
    end
  end

  // Delivered-result counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_done <= '0;
    else if (w_out_hs) r_done <= r_done + 1'b1;
  end
endmodule
